// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pkg : shared types and helpers for the ifetch_pq fetch unit       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package if_pkg;

   localparam logic [6:0] OPCODE_JAL = 7'b1101111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LAST  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        pred;
   } if_entry_t;

   // Sign-extended J-type immediate (byte offset, bit 0 always zero).
   function automatic logic [31:0] j_imm(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifq_fifo : show-ahead FIFO of fetched instructions with clear        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ifq_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     i_push,
   input  if_entry_t                i_din,
   input  logic                     i_pop,
   input  logic                     i_clr,
   output if_entry_t                o_dout,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   if_entry_t       r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != C_FULL) || w_pop);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop)
            r_count <= r_count - (AW+1)'(1);
      end
   end

   // Storage carries no reset; entries are only read while counted valid.
   always_ff @(posedge clk_in) begin
      if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_pq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_pq : RISC-V fetch unit, multi-beat memory port, JAL predict,  |
// |             instruction queue and ROB flush redirect                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ifetch_pq
   import if_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 4,
   parameter int          MEM_BYTES   = 1,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter bit          JAL_PREDICT = 1'b1
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           rdy_in,
   input  logic                           flush,
   input  logic [31:0]                    flush_pc,
   input  logic                           mem_grant,
   input  logic [8*MEM_BYTES-1:0]         mem_din,
   output logic                           mem_req,
   output logic [31:0]                    mem_a,
   output logic                           mem_wr,
   output logic                           dec_valid,
   input  logic                           dec_ready,
   output logic [31:0]                    dec_ins,
   output logic [31:0]                    dec_pc,
   output logic                           dec_pred_taken,
   output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

   localparam int              BEATS       = 4 / MEM_BYTES;
   localparam int              BW          = 8 * MEM_BYTES;
   localparam int              CW          = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [1:0]      C_LAST_BEAT = 2'(BEATS - 1);
   localparam logic [31:0]     C_STEP      = 32'(MEM_BYTES);
   localparam logic [CW-1:0]   C_DEPTH     = CW'(QUEUE_DEPTH);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;
   logic [31:0]      r_pc;
   logic [31:0]      r_buf;
   logic [1:0]       r_acc_cnt;
   logic [1:0]       r_ret_cnt;
   logic             r_pend;

   logic             w_accept;
   logic             w_pop;
   logic             w_push;
   logic             w_clr;
   logic             w_start;
   logic [31:0]      w_start_a;
   logic             w_is_jal;
   logic [31:0]      w_word;
   logic [31:0]      w_next_pc;
   logic [CW-1:0]    w_count_after;
   if_entry_t        w_entry;
   if_entry_t        w_head;

   assign w_accept = rdy_in && mem_req && mem_grant;
   assign w_clr    = rdy_in && flush;
   assign w_pop    = rdy_in && !flush && dec_valid && dec_ready;

   // Returning beat overlays its slot so the final beat completes the word in LAST.
   for (genvar k = 0; k < BEATS; k++) begin : g_beat
      assign w_word[k*BW +: BW] = (r_ret_cnt == 2'(k)) ? mem_din : r_buf[k*BW +: BW];
   end

   assign w_is_jal      = JAL_PREDICT && (w_word[6:0] == OPCODE_JAL);
   assign w_next_pc     = w_is_jal ? ((r_pc + j_imm(w_word)) & 32'hFFFF_FFFC)
                                   : (r_pc + 32'd4);
   assign w_count_after = q_count + CW'(1) - CW'(w_pop);
   assign w_entry       = '{ins: w_word, pc: r_pc, pred: w_is_jal};

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_start     = 1'b0;
      w_start_a   = r_pc;
      if (rdy_in) begin
         if (flush) begin
            w_state_nxt = IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (q_count < C_DEPTH) begin
                     w_state_nxt = FETCH;
                     w_start     = 1'b1;
                  end
               end
               FETCH: begin
                  if (w_accept && (r_acc_cnt == C_LAST_BEAT)) w_state_nxt = LAST;
               end
               LAST: begin
                  w_push    = 1'b1;
                  w_start_a = w_next_pc;
                  if (w_count_after < C_DEPTH) begin
                     w_state_nxt = FETCH;
                     w_start     = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
               default: w_state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_req   <= 1'b0;
         mem_a     <= RESET_PC;
         r_pc      <= RESET_PC;
         r_buf     <= '0;
         r_acc_cnt <= '0;
         r_ret_cnt <= '0;
         r_pend    <= 1'b0;
      end else if (rdy_in) begin
         if (flush) begin
            // Dropping r_pend discards the return of a beat accepted on this edge.
            r_pc      <= flush_pc & 32'hFFFF_FFFC;
            mem_req   <= 1'b0;
            r_acc_cnt <= '0;
            r_ret_cnt <= '0;
            r_pend    <= 1'b0;
         end else begin
            r_pend <= w_accept;
            if (w_accept) begin
               mem_a <= mem_a + C_STEP;
               if (r_acc_cnt == C_LAST_BEAT) begin
                  r_acc_cnt <= '0;
                  mem_req   <= 1'b0;
               end else begin
                  r_acc_cnt <= r_acc_cnt + 2'd1;
               end
            end
            if (r_pend && (r_state == FETCH)) begin
               r_buf     <= w_word;
               r_ret_cnt <= r_ret_cnt + 2'd1;
            end
            if (r_state == LAST) begin
               r_pc      <= w_next_pc;
               r_ret_cnt <= '0;
            end
            if (w_start) begin
               mem_req <= 1'b1;
               mem_a   <= w_start_a;
            end
         end
      end
   end

   ifq_fifo #(
      .DEPTH   (QUEUE_DEPTH)
   ) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_push  (w_push),
      .i_din   (w_entry),
      .i_pop   (w_pop),
      .i_clr   (w_clr),
      .o_dout  (w_head),
      .o_valid (dec_valid),
      .o_count (q_count)
   );

   assign mem_wr         = 1'b0;
   assign dec_ins        = w_head.ins;
   assign dec_pc         = w_head.pc;
   assign dec_pred_taken = w_head.pred;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_pq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch_pq : directed self-checking bench for ifetch_pq            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_ifetch_pq;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   logic rst_in;

   // Instance A: byte-wide port, depth 4, reset PC 0
   logic        rdy_a, grant_a, dr_a, flush_a;
   logic [31:0] fpc_a;
   logic [7:0]  din_a = 8'h0;
   logic        req_a, wr_a, v_a, pred_a;
   logic [31:0] a_a, ins_a, pc_a;
   logic [2:0]  q_a;

   // Instances B/C: word-wide port, reset PC 0x100, JAL predict on/off
   logic [31:0] din_b = 32'h0, din_c = 32'h0;
   logic        req_b, wr_b, v_b, pred_b, req_c, wr_c, v_c, pred_c;
   logic [31:0] a_b, ins_b, pc_b, a_c, ins_c, pc_c;
   logic [2:0]  q_b, q_c;

   ifetch_pq #(.QUEUE_DEPTH(4), .MEM_BYTES(1), .RESET_PC(32'h0), .JAL_PREDICT(1'b1)) u_a (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_a), .flush(flush_a), .flush_pc(fpc_a),
      .mem_grant(grant_a), .mem_din(din_a), .mem_req(req_a), .mem_a(a_a), .mem_wr(wr_a),
      .dec_valid(v_a), .dec_ready(dr_a), .dec_ins(ins_a), .dec_pc(pc_a),
      .dec_pred_taken(pred_a), .q_count(q_a));

   ifetch_pq #(.QUEUE_DEPTH(4), .MEM_BYTES(4), .RESET_PC(32'h100), .JAL_PREDICT(1'b1)) u_b (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(1'b1), .flush(1'b0), .flush_pc(32'h0),
      .mem_grant(1'b1), .mem_din(din_b), .mem_req(req_b), .mem_a(a_b), .mem_wr(wr_b),
      .dec_valid(v_b), .dec_ready(1'b0), .dec_ins(ins_b), .dec_pc(pc_b),
      .dec_pred_taken(pred_b), .q_count(q_b));

   ifetch_pq #(.QUEUE_DEPTH(4), .MEM_BYTES(4), .RESET_PC(32'h100), .JAL_PREDICT(1'b0)) u_c (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(1'b1), .flush(1'b0), .flush_pc(32'h0),
      .mem_grant(1'b1), .mem_din(din_c), .mem_req(req_c), .mem_a(a_c), .mem_wr(wr_c),
      .dec_valid(v_c), .dec_ready(1'b0), .dec_ins(ins_c), .dec_pc(pc_c),
      .dec_pred_taken(pred_c), .q_count(q_c));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0010_0513;
         32'h0000_0100: return 32'h0100_006F;
         default:       return (a << 8) | 32'h13;
      endcase
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word({a[31:2], 2'b00});
      return w[8*a[1:0] +: 8];
   endfunction

   // Memory answers a beat accepted at an edge on the following cycle and holds otherwise.
   always @(posedge clk_in) begin
      if (rdy_a && req_a && grant_a) din_a <= mem_byte(a_a);
      if (req_b) din_b <= mem_word(a_b);
      if (req_c) din_c <= mem_word(a_c);
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   typedef struct {
      bit          rdy, grant, dr;
      bit          req;
      logic [31:0] a;
      bit          v;
      int          q;
      bit          hd;
      logic [31:0] ins, pc;
      bit          pred;
   } vec_t;

   function automatic vec_t mk(bit rdy, bit grant, bit dr, bit req, logic [31:0] a, bit v, int q,
                               bit hd, logic [31:0] ins, logic [31:0] pc);
      vec_t t;
      t.rdy = rdy; t.grant = grant; t.dr = dr; t.req = req; t.a = a; t.v = v; t.q = q;
      t.hd = hd; t.ins = ins; t.pc = pc; t.pred = 1'b0;
      return t;
   endfunction

   vec_t vt [19];

   initial begin
      // Byte fetch of pc 0 with a 3-cycle grant gap, then pc 4 with a 5-cycle rdy stall.
      vt[0]  = mk(1,1,0, 1,32'd0,0,0, 0,0,0);
      vt[1]  = mk(1,1,0, 1,32'd1,0,0, 0,0,0);
      vt[2]  = mk(1,1,0, 1,32'd2,0,0, 0,0,0);
      vt[3]  = mk(1,0,0, 1,32'd2,0,0, 0,0,0);
      vt[4]  = mk(1,0,0, 1,32'd2,0,0, 0,0,0);
      vt[5]  = mk(1,0,0, 1,32'd2,0,0, 0,0,0);
      vt[6]  = mk(1,1,0, 1,32'd3,0,0, 0,0,0);
      vt[7]  = mk(1,1,0, 0,32'd4,0,0, 0,0,0);
      vt[8]  = mk(1,1,0, 1,32'd4,1,1, 1,32'h0010_0513,32'h0);
      vt[9]  = mk(1,1,0, 1,32'd5,1,1, 0,0,0);
      for (int i = 10; i < 15; i++)
         vt[i] = mk(0,1,1, 1,32'd5,1,1, 1,32'h0010_0513,32'h0);
      vt[15] = mk(1,1,0, 1,32'd6,1,1, 0,0,0);
      vt[16] = mk(1,1,0, 1,32'd7,1,1, 0,0,0);
      vt[17] = mk(1,1,0, 0,32'd8,1,1, 0,0,0);
      vt[18] = mk(1,1,0, 1,32'd8,1,2, 1,32'h0010_0513,32'h0);

      rst_in = 1'b1; rdy_a = 1'b0; grant_a = 1'b0; dr_a = 1'b0; flush_a = 1'b0; fpc_a = '0;
      #23 rst_in = 1'b0;
      #1;
      chk("rst.req_a", 32'(req_a), 32'd0);
      chk("rst.mem_a_a", a_a, 32'h0);
      chk("rst.valid_a", 32'(v_a), 32'd0);
      chk("rst.q_a", 32'(q_a), 32'd0);
      chk("rst.wr_a", 32'(wr_a), 32'd0);
      chk("rst.mem_a_b", a_b, 32'h100);
      chk("rst.req_b", 32'(req_b), 32'd0);

      // Word-wide JAL prediction, A held by rdy low meanwhile
      tick();
      chk("jal.e1.req_b", 32'(req_b), 32'd1);
      chk("jal.e1.mem_a_b", a_b, 32'h100);
      tick();
      chk("jal.e2.req_b", 32'(req_b), 32'd0);
      tick();
      chk("jal.push.mem_a_b", a_b, 32'h110);
      chk("jal.push.req_b", 32'(req_b), 32'd1);
      chk("jal.push.ins_b", ins_b, 32'h0100_006F);
      chk("jal.push.pc_b", pc_b, 32'h100);
      chk("jal.push.pred_b", 32'(pred_b), 32'd1);
      chk("nojal.mem_a_c", a_c, 32'h104);
      chk("nojal.pred_c", 32'(pred_c), 32'd0);
      chk("nojal.ins_c", ins_c, 32'h0100_006F);
      tick();
      chk("jal.e4.mem_a_b", a_b, 32'h114);
      tick();
      chk("jal.e5.q_b", 32'(q_b), 32'd2);
      chk("jal.e5.mem_a_b", a_b, 32'h114);
      chk("jal.wr_b", 32'(wr_b | wr_c), 32'd0);
      chk("rstheld.q_a", 32'(q_a), 32'd0);

      for (int i = 0; i < 19; i++) begin
         rdy_a = vt[i].rdy; grant_a = vt[i].grant; dr_a = vt[i].dr;
         tick();
         chk($sformatf("vec%0d.req", i), 32'(req_a), 32'(vt[i].req));
         chk($sformatf("vec%0d.mem_a", i), a_a, vt[i].a);
         chk($sformatf("vec%0d.valid", i), 32'(v_a), 32'(vt[i].v));
         chk($sformatf("vec%0d.q", i), 32'(q_a), 32'(vt[i].q));
         if (vt[i].hd) begin
            chk($sformatf("vec%0d.ins", i), ins_a, vt[i].ins);
            chk($sformatf("vec%0d.pc", i), pc_a, vt[i].pc);
            chk($sformatf("vec%0d.pred", i), 32'(pred_a), 32'(vt[i].pred));
         end
      end

      // Queue fills with pc 8 and pc 12, then fetch idles
      rdy_a = 1'b1; grant_a = 1'b1; dr_a = 1'b0;
      repeat (10) tick();
      chk("full.q", 32'(q_a), 32'd4);
      chk("full.req", 32'(req_a), 32'd0);
      repeat (5) tick();
      chk("full.hold.q", 32'(q_a), 32'd4);
      chk("full.hold.req", 32'(req_a), 32'd0);
      chk("full.head.pc", pc_a, 32'h0);
      dr_a = 1'b1;
      tick();
      dr_a = 1'b0;
      chk("pop.q", 32'(q_a), 32'd3);
      chk("pop.head.pc", pc_a, 32'h4);
      chk("pop.head.ins", ins_a, 32'h0000_0413);
      chk("pop.req", 32'(req_a), 32'd0);
      tick();
      chk("resume.req", 32'(req_a), 32'd1);
      chk("resume.mem_a", a_a, 32'h10);

      // Flush after two beats, with a third beat accepted on the flush edge
      tick();
      tick();
      chk("preflush.mem_a", a_a, 32'h12);
      flush_a = 1'b1; fpc_a = 32'h2003;
      tick();
      flush_a = 1'b0; fpc_a = 32'h0;
      chk("flush.q", 32'(q_a), 32'd0);
      chk("flush.valid", 32'(v_a), 32'd0);
      chk("flush.req", 32'(req_a), 32'd0);
      tick();
      chk("refetch.req", 32'(req_a), 32'd1);
      chk("refetch.mem_a", a_a, 32'h2000);
      repeat (5) tick();
      chk("refetch.q", 32'(q_a), 32'd1);
      chk("refetch.ins", ins_a, 32'h0020_0013);
      chk("refetch.pc", pc_a, 32'h2000);
      chk("refetch.pred", 32'(pred_a), 32'd0);

      // Asynchronous reset in the middle of a fetch
      tick();
      tick();
      #2 rst_in = 1'b1;
      #1;
      chk("arst.req", 32'(req_a), 32'd0);
      chk("arst.mem_a", a_a, 32'h0);
      chk("arst.q", 32'(q_a), 32'd0);
      chk("arst.valid", 32'(v_a), 32'd0);
      #20 rst_in = 1'b0;
      #10;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
